// File: rtl/dma_arbiter.sv
// dma_arbiter: round-robin sharing of one DMA engine between two requesters.
// Each port latches a single pending request; the arbiter issues one transfer
// at a time, holds ownership until the engine finishes, and returns the finish
// pulse to the owning port. A watchdog flags transfers that never complete.
module dma_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_start,
  input  logic [31:0] req0_addr,
  output logic        req0_pending,
  output logic        req0_finish,
  input  logic        req1_start,
  input  logic [31:0] req1_addr,
  output logic        req1_pending,
  output logic        req1_finish,
  output logic [31:0] dma_engine_src_addr,
  output logic        dma_engine_start,
  input  logic        dma_engine_finish,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_MAX - 1'b1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic [1:0]       r_pend;
  logic [1:0][31:0] r_addr;
  logic [1:0]       r_fin;
  logic [31:0]      r_src;
  logic             r_start;
  logic             r_busy;
  logic             r_owner;
  logic             r_last;
  logic             r_tmo;
  logic [WD_W-1:0]  r_wd;

  logic [1:0]       w_start;
  logic [1:0][31:0] w_req_addr;
  logic             w_issue;
  logic             w_sel;

  assign w_start    = {req1_start, req0_start};
  assign w_req_addr = {req1_addr, req0_addr};

  // Tie goes to the port that did not win last; otherwise the lone pending port.
  assign w_sel   = (r_pend[0] && r_pend[1]) ? ~r_last : r_pend[1];
  assign w_issue = (r_state == S_IDLE) && (r_pend != 2'b00);

  // Per-port one-deep request latch; issue clears it, a start while full is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_addr <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_issue && (w_sel == 1'(n))) begin
          r_pend[n] <= 1'b0;
        end else if (w_start[n] && !r_pend[n]) begin
          r_pend[n] <= 1'b1;
          r_addr[n] <= w_req_addr[n];
        end
      end
    end
  end

  // Arbitration FSM with registered engine/requester handshakes and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_start <= 1'b0;
      r_fin   <= '0;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_tmo   <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_start <= 1'b0;
      r_fin   <= '0;
      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (w_issue) begin
            r_src   <= r_addr[w_sel];
            r_start <= 1'b1;
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dma_engine_finish) begin
            r_fin[r_owner] <= 1'b1;
            r_busy  <= 1'b0;
            r_wd    <= '0;
            r_state <= S_IDLE;
          end else begin
            if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
            // Counter is about to reach the limit on this edge.
            if ((TIMEOUT_CYCLES != 0) && (r_wd == WD_LAST)) r_tmo <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_pending        = r_pend[0];
  assign req1_pending        = r_pend[1];
  assign req0_finish         = r_fin[0];
  assign req1_finish         = r_fin[1];
  assign dma_engine_src_addr = r_src;
  assign dma_engine_start    = r_start;
  assign busy                = r_busy;
  assign owner               = r_owner;
  assign timeout_err         = r_tmo;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter with a 16-cycle watchdog.
module tb_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_start = 1'b0;
  logic [31:0] req0_addr = '0;
  logic        req0_pending, req0_finish;
  logic        req1_start = 1'b0;
  logic [31:0] req1_addr = '0;
  logic        req1_pending, req1_finish;
  logic [31:0] dma_engine_src_addr;
  logic        dma_engine_start;
  logic        dma_engine_finish = 1'b0;
  logic        busy, owner, timeout_err;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_addr [2];
  logic        exp_port;

  dma_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_start(req0_start), .req0_addr(req0_addr),
    .req0_pending(req0_pending), .req0_finish(req0_finish),
    .req1_start(req1_start), .req1_addr(req1_addr),
    .req1_pending(req1_pending), .req1_finish(req1_finish),
    .dma_engine_src_addr(dma_engine_src_addr),
    .dma_engine_start(dma_engine_start),
    .dma_engine_finish(dma_engine_finish),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src"},   dma_engine_src_addr, 32'h0);
    chk({tag, "_start"}, {31'd0, dma_engine_start}, 32'd0);
    chk({tag, "_pend"},  {30'd0, req1_pending, req0_pending}, 32'd0);
    chk({tag, "_fin"},   {30'd0, req1_finish, req0_finish}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, 32'd0);
    chk({tag, "_tmo"},   {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic chk_issue(input string tag, input logic port, input logic [31:0] addr);
    chk({tag, "_start"}, {31'd0, dma_engine_start}, 32'd1);
    chk({tag, "_addr"},  dma_engine_src_addr, addr);
    chk({tag, "_owner"}, {31'd0, owner}, {31'd0, port});
    chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
  endtask

  // Pulse engine finish for one cycle and check the routed finish pulse.
  task automatic do_finish(input string tag, input logic port);
    dma_engine_finish = 1'b1;
    tick();
    dma_engine_finish = 1'b0;
    chk({tag, "_fin"},  {30'd0, req1_finish, req0_finish}, port ? 32'd2 : 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request on port 0
    req0_start = 1'b1; req0_addr = 32'h2000_0000;
    tick();
    req0_start = 1'b0;
    chk("single_pend", {31'd0, req0_pending}, 32'd1);
    chk("single_nostart", {31'd0, dma_engine_start}, 32'd0);
    tick();
    chk_issue("single_issue", 1'b0, 32'h2000_0000);
    chk("single_pend_clr", {31'd0, req0_pending}, 32'd0);
    tick();
    chk("single_start_1cyc", {31'd0, dma_engine_start}, 32'd0);
    chk("single_addr_hold", dma_engine_src_addr, 32'h2000_0000);
    repeat (5) tick();
    do_finish("single", 1'b0);
    tick();
    chk("single_fin_1cyc", {30'd0, req1_finish, req0_finish}, 32'd0);

    // Simultaneous requests after reset: port 0, then port 1, then port 0 again
    do_reset();
    req0_start = 1'b1; req0_addr = 32'h100;
    req1_start = 1'b1; req1_addr = 32'h200;
    tick();
    req0_start = 1'b0; req1_start = 1'b0;
    chk("sim_pend", {30'd0, req1_pending, req0_pending}, 32'd3);
    tick();
    chk_issue("sim_first", 1'b0, 32'h100);
    chk("sim_p1_wait", {31'd0, req1_pending}, 32'd1);
    tick();
    do_finish("sim_first", 1'b0);
    chk("sim_idle_gap", {31'd0, dma_engine_start}, 32'd0);
    tick();
    chk_issue("sim_second", 1'b1, 32'h200);
    tick();
    do_finish("sim_second", 1'b1);
    req0_start = 1'b1; req0_addr = 32'h110;
    req1_start = 1'b1; req1_addr = 32'h210;
    tick();
    req0_start = 1'b0; req1_start = 1'b0;
    tick();
    chk_issue("sim_again", 1'b0, 32'h110);
    tick();
    do_finish("sim_again", 1'b0);
    tick();
    chk_issue("sim_again2", 1'b1, 32'h210);
    tick();
    do_finish("sim_again2", 1'b1);
    tick();

    // Fairness: both always pending; owner re-requests during its transfer
    req0_start = 1'b1; req0_addr = 32'h1000;
    req1_start = 1'b1; req1_addr = 32'h2000;
    exp_addr[0] = 32'h1000; exp_addr[1] = 32'h2000;
    tick();
    req0_start = 1'b0; req1_start = 1'b0;
    exp_port = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 10 && !dma_engine_start; w++) tick();
      chk_issue($sformatf("rr%0d", k), exp_port, exp_addr[exp_port]);
      if (exp_port) begin
        req1_start = 1'b1; req1_addr = 32'h2100 + k;
      end else begin
        req0_start = 1'b1; req0_addr = 32'h1100 + k;
      end
      exp_addr[exp_port] = exp_port ? 32'h2100 + k : 32'h1100 + k;
      tick();
      req0_start = 1'b0; req1_start = 1'b0;
      do_finish($sformatf("rr%0d", k), exp_port);
      exp_port = ~exp_port;
    end

    // Drop and overlap on port 1
    do_reset();
    req1_start = 1'b1; req1_addr = 32'h500;
    tick();
    req1_start = 1'b0;
    tick();
    chk_issue("ovl_first", 1'b1, 32'h500);
    req1_start = 1'b1; req1_addr = 32'h300;
    tick();
    chk("ovl_accept", {31'd0, req1_pending}, 32'd1);
    req1_addr = 32'h400;
    tick();
    req1_start = 1'b0;
    chk("ovl_drop_pend", {31'd0, req1_pending}, 32'd1);
    do_finish("ovl_first", 1'b1);
    tick();
    chk_issue("ovl_second", 1'b1, 32'h300);
    chk("ovl_no_extra", {31'd0, req1_pending}, 32'd0);
    tick();
    do_finish("ovl_second", 1'b1);
    tick();

    // Stray finish in IDLE
    dma_engine_finish = 1'b1;
    tick();
    dma_engine_finish = 1'b0;
    chk("stray_fin", {30'd0, req1_finish, req0_finish}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("stray_fin2", {30'd0, req1_finish, req0_finish}, 32'd0);

    // Watchdog: withhold finish
    req0_start = 1'b1; req0_addr = 32'hABC;
    tick();
    req0_start = 1'b0;
    tick();
    chk_issue("wd_issue", 1'b0, 32'hABC);
    repeat (15) tick();
    chk("wd_before", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("wd_set", {31'd0, timeout_err}, 32'd1);
    chk("wd_busy", {31'd0, busy}, 32'd1);
    repeat (3) tick();
    chk("wd_sticky", {31'd0, timeout_err}, 32'd1);
    do_finish("wd_late", 1'b0);
    chk("wd_sticky_idle", {31'd0, timeout_err}, 32'd1);
    tick();

    // Reset mid-BUSY with port 1 pending
    do_reset();
    chk("rst_clears_tmo", {31'd0, timeout_err}, 32'd0);
    req0_start = 1'b1; req0_addr = 32'h7000;
    tick();
    req0_start = 1'b0;
    tick();
    chk_issue("rstb_issue", 1'b0, 32'h7000);
    req1_start = 1'b1; req1_addr = 32'h7100;
    tick();
    req1_start = 1'b0;
    chk("rstb_p1_pend", {31'd0, req1_pending}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    tick();
    rst = 1'b0;
    dma_engine_finish = 1'b1;
    tick();
    dma_engine_finish = 1'b0;
    chk("rst_late_fin", {30'd0, req1_finish, req0_finish}, 32'd0);
    tick();
    chk_reset_outputs("rst_after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
